// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// CPU-side initiator for the data port of the unified instruction/data
// memory. Takes one load/store at a time from the execute stage over a
// valid/ready handshake, runs the memory-side sequence and returns exactly
// one response pulse per accepted request.
//
// Memory is big-endian: the byte at address A lives in bits 31:24 of the
// word read at A. Sub-word stores are done as read-modify-write: the word is
// read first, the new byte/halfword is merged into its top bits, and the
// full word is written back.
//
// Parameters
//   READ_LATENCY  cycles address/read are held before read data is captured
//                 (1..15)
//   MEM_BYTES     memory size in bytes; legal iff addr+3 < MEM_BYTES
//   IDLE_ADDR     address parked on data_memory_a while idle
//
// Ports
//   mem_Clk            clock, rising edge
//   mem_Reset_n        asynchronous active-low reset
//   req_valid          request present
//   req_ready          unit can accept a request this cycle
//   req_write          1 = store, 0 = load
//   req_size           00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed         loads only: sign-extend (1) / zero-extend (0)
//   req_addr           byte address
//   req_wdata          store data, right-justified for sub-word sizes
//   resp_valid         one-cycle response pulse
//   resp_rdata         extended load result; 0 for stores and errors
//   resp_error         error flag, qualified by resp_valid
//   data_memory_a      memory byte address
//   data_memory_read   memory read enable
//   data_memory_write  memory write enable
//   data_memory_out_v  store word to memory
//   data_memory_in_v   read word from memory
//
// State table
//   state | meaning
//   IDLE  | waiting for a request; address parked on IDLE_ADDR
//   READ  | address + read enable held READ_LATENCY cycles, data captured
//         | on the last edge
//   WRITE | one-cycle write of the (possibly merged) store word
//   RESP  | one-cycle response pulse, memory side parked
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MEM_BYTES    = 65536,
  parameter logic [31:0] IDLE_ADDR    = 32'hFFFF_FFFC
) (
  input  logic        mem_Clk,
  input  logic        mem_Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] data_memory_a,
  output logic        data_memory_read,
  output logic        data_memory_write,
  output logic [31:0] data_memory_out_v,
  input  logic [31:0] data_memory_in_v
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  // Down-counter reload: the counter hits zero on the last READ edge.
  localparam logic [3:0] LAT_RELOAD = 4'(READ_LATENCY - 1);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state;
  logic [3:0]  lat_cnt;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_signed;
  // Only the low halfword is needed after acceptance; word stores drive
  // data_memory_out_v straight from req_wdata at the accepting edge.
  logic [15:0] op_wdata;

  logic        acc_err;

  // Acceptance-time error check. The range check is done in 33 bits so an
  // address near 2^32 cannot wrap around into a legal-looking value.
  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [31:0] addr);
    logic [32:0] last_byte;
    logic        err;
    last_byte = {1'b0, addr} + 33'd3;
    err = 1'b0;
    if (size == SIZE_BAD)
      err = 1'b1;
    else if ((size == SIZE_HALF) && addr[0])
      err = 1'b1;
    else if ((size == SIZE_WORD) && (addr[1:0] != 2'b00))
      err = 1'b1;
    else if (last_byte >= MEM_LIMIT)
      err = 1'b1;
    else if (addr == IDLE_ADDR)
      err = 1'b1;
    return err;
  endfunction

  // Load extraction from the captured word (big-endian: lowest address in
  // the top bits).
  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [31:0] w);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {{24{sgn & w[31]}}, w[31:24]};
      SIZE_HALF: r = {{16{sgn & w[31]}}, w[31:16]};
      default:   r = w;
    endcase
    return r;
  endfunction

  // Merge of store data into the captured word for read-modify-write.
  function automatic logic [31:0] store_merge(input logic [1:0]  size,
                                              input logic [15:0] wd,
                                              input logic [31:0] w);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {wd[7:0], w[23:0]};
      SIZE_HALF: r = {wd[15:0], w[15:0]};
      default:   r = w;
    endcase
    return r;
  endfunction

  assign acc_err   = access_error(req_size, req_addr);
  assign req_ready = (state == IDLE) && mem_Reset_n;

  always_ff @(posedge mem_Clk or negedge mem_Reset_n) begin
    if (!mem_Reset_n) begin
      state             <= IDLE;
      lat_cnt           <= 4'd0;
      op_write          <= 1'b0;
      op_size           <= 2'b00;
      op_signed         <= 1'b0;
      op_wdata          <= 16'h0000;
      resp_valid        <= 1'b0;
      resp_rdata        <= 32'h0000_0000;
      resp_error        <= 1'b0;
      data_memory_a     <= IDLE_ADDR;
      data_memory_read  <= 1'b0;
      data_memory_write <= 1'b0;
      data_memory_out_v <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            op_write  <= req_write;
            op_size   <= req_size;
            op_signed <= req_signed;
            op_wdata  <= req_wdata[15:0];
            if (acc_err) begin
              // Memory side stays parked; go straight to the response.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else if (req_write && (req_size == SIZE_WORD)) begin
              state             <= WRITE;
              data_memory_a     <= req_addr;
              data_memory_write <= 1'b1;
              data_memory_out_v <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a read.
              state            <= READ;
              data_memory_a    <= req_addr;
              data_memory_read <= 1'b1;
              lat_cnt          <= LAT_RELOAD;
            end
          end
        end

        READ: begin
          if (lat_cnt == 4'd0) begin
            data_memory_read <= 1'b0;
            if (op_write) begin
              // Address is kept; only the enables change for the write.
              state             <= WRITE;
              data_memory_write <= 1'b1;
              data_memory_out_v <= store_merge(op_size, op_wdata,
                                               data_memory_in_v);
            end else begin
              state         <= RESP;
              data_memory_a <= IDLE_ADDR;
              resp_valid    <= 1'b1;
              resp_error    <= 1'b0;
              resp_rdata    <= load_extract(op_size, op_signed,
                                            data_memory_in_v);
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        WRITE: begin
          state             <= RESP;
          data_memory_write <= 1'b0;
          data_memory_a     <= IDLE_ADDR;
          resp_valid        <= 1'b1;
          resp_error        <= 1'b0;
          resp_rdata        <= 32'h0000_0000;
        end

        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end

        default: begin
          state             <= IDLE;
          resp_valid        <= 1'b0;
          data_memory_a     <= IDLE_ADDR;
          data_memory_read  <= 1'b0;
          data_memory_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [31:0] IDLE_A = 32'hFFFF_FFFC;

  logic        mem_Clk;
  logic        mem_Reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] data_memory_a;
  logic        data_memory_read;
  logic        data_memory_write;
  logic [31:0] data_memory_out_v;
  logic [31:0] data_memory_in_v;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(
    .READ_LATENCY(1),
    .MEM_BYTES(65536),
    .IDLE_ADDR(32'hFFFF_FFFC)
  ) dut (
    .mem_Clk(mem_Clk),
    .mem_Reset_n(mem_Reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .data_memory_a(data_memory_a),
    .data_memory_read(data_memory_read),
    .data_memory_write(data_memory_write),
    .data_memory_out_v(data_memory_out_v),
    .data_memory_in_v(data_memory_in_v)
  );

  initial mem_Clk = 1'b0;
  always #5 mem_Clk = ~mem_Clk;

  // Big-endian byte memory, combinational read, word write on clock edge.
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_base;
  always_comb begin
    data_memory_in_v = 32'h0;
    rd_base = data_memory_a[15:0];
    if (data_memory_a <= 32'h0000_FFFC)
      data_memory_in_v = {mem[rd_base], mem[rd_base + 16'd1],
                          mem[rd_base + 16'd2], mem[rd_base + 16'd3]};
  end

  always @(posedge mem_Clk) begin
    if (data_memory_write && (data_memory_a <= 32'h0000_FFFC)) begin
      mem[data_memory_a[15:0]]         <= data_memory_out_v[31:24];
      mem[data_memory_a[15:0] + 16'd1] <= data_memory_out_v[23:16];
      mem[data_memory_a[15:0] + 16'd2] <= data_memory_out_v[15:8];
      mem[data_memory_a[15:0] + 16'd3] <= data_memory_out_v[7:0];
    end
  end

  task automatic poke(input logic [15:0] a, input logic [31:0] w);
    mem[a]         = w[31:24];
    mem[a + 16'd1] = w[23:16];
    mem[a + 16'd2] = w[15:8];
    mem[a + 16'd3] = w[7:0];
  endtask

  // Issues one request and watches the memory side until the response.
  // lat is the cycle number (1 = cycle after the accepting edge) of resp_valid.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic er, output int wr_cyc,
                        output logic [31:0] wv, output logic rd_seen,
                        output logic a_moved);
    int guard;
    lat = -1; rd = 32'hX; er = 1'bX; wr_cyc = 0; wv = 32'h0;
    rd_seen = 1'b0; a_moved = 1'b0;
    @(negedge mem_Clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge mem_Clk);
      guard++;
    end
    req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd; req_valid = 1'b1;
    @(posedge mem_Clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'h5555_5555;
    req_wdata = 32'hAAAA_AAAA;
    for (int k = 1; k <= 40; k++) begin
      @(negedge mem_Clk);
      if (data_memory_write) begin
        wr_cyc++;
        wv = data_memory_out_v;
      end
      if (data_memory_read) rd_seen = 1'b1;
      if (data_memory_a !== IDLE_A) a_moved = 1'b1;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_error;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL rst_error got %b exp 0", resp_error); end
    n_checks++; if (data_memory_a !== IDLE_A) begin n_fail++; $display("FAIL rst_addr got %h exp %h", data_memory_a, IDLE_A); end
    n_checks++; if (data_memory_read !== 1'b0 || data_memory_write !== 1'b0) begin n_fail++; $display("FAIL rst_rw got %b%b exp 00", data_memory_read, data_memory_write); end
    n_checks++; if (data_memory_out_v !== 32'h0) begin n_fail++; $display("FAIL rst_out_v got %h exp 0", data_memory_out_v); end
    @(negedge mem_Clk);
    mem_Reset_n = 1'b1;
    @(negedge mem_Clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word_rw;
    int lat, wc; logic [31:0] rd, wv; logic er, rs, am;
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, lat, rd, er, wc, wv, rs, am);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wst_latency got %0d exp 2", lat); end
    n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL wst_write_cycles got %0d exp 1", wc); end
    n_checks++; if (wv !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wst_out_v got %h exp deadbeef", wv); end
    n_checks++; if (rs !== 1'b0) begin n_fail++; $display("FAIL wst_no_read got %b exp 0", rs); end
    n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL wst_resp got err=%b rdata=%h exp 0/0", er, rd); end
    @(negedge mem_Clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wst_resp_pulse got %b exp 0", resp_valid); end
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er, wc, wv, rs, am);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wld_latency got %0d exp 2", lat); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wld_rdata got %h exp deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wld_error got %b exp 0", er); end
    n_checks++; if (wc !== 0 || rs !== 1'b1) begin n_fail++; $display("FAIL wld_rw got wc=%0d read=%b exp 0/1", wc, rs); end
  endtask

  task automatic test_sub_loads;
    int lat, wc; logic [31:0] rd, wv; logic er, rs, am;
    logic [1:0]  sz  [4];
    logic        sg  [4];
    logic [31:0] exp [4];
    sz[0] = 2'b00; sg[0] = 1'b1; exp[0] = 32'hFFFF_FF80;
    sz[1] = 2'b00; sg[1] = 1'b0; exp[1] = 32'h0000_0080;
    sz[2] = 2'b01; sg[2] = 1'b1; exp[2] = 32'hFFFF_8011;
    sz[3] = 2'b01; sg[3] = 1'b0; exp[3] = 32'h0000_8011;
    poke(16'h0200, 32'h8011_2233);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], sg[i], 32'h200, 32'h0, lat, rd, er, wc, wv, rs, am);
      n_checks++; if (rd !== exp[i] || er !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL subload_%0d got rdata=%h err=%b lat=%0d exp %h/0/2", i, rd, er, lat, exp[i]); end
    end
    poke(16'hFFFC, 32'h0102_0304);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFC, 32'h0, lat, rd, er, wc, wv, rs, am);
    n_checks++; if (rd !== 32'h0102_0304 || er !== 1'b0) begin n_fail++; $display("FAIL top_word_load got rdata=%h err=%b exp 01020304/0", rd, er); end
  endtask

  task automatic test_rmw_store;
    int lat, wc; logic [31:0] rd, wv; logic er, rs, am;
    poke(16'h0300, 32'h1122_3344);
    do_req(1'b1, 2'b01, 1'b0, 32'h300, 32'h0000_ABCD, lat, rd, er, wc, wv, rs, am);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL hst_latency got %0d exp 3", lat); end
    n_checks++; if (rs !== 1'b1 || wc !== 1) begin n_fail++; $display("FAIL hst_rw got read=%b wc=%0d exp 1/1", rs, wc); end
    n_checks++; if (wv !== 32'hABCD_3344) begin n_fail++; $display("FAIL hst_out_v got %h exp abcd3344", wv); end
    do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, lat, rd, er, wc, wv, rs, am);
    n_checks++; if (rd !== 32'hABCD_3344) begin n_fail++; $display("FAIL hst_readback got %h exp abcd3344", rd); end
    poke(16'h0304, 32'h5566_7788);
    do_req(1'b1, 2'b00, 1'b0, 32'h304, 32'h1234_56EE, lat, rd, er, wc, wv, rs, am);
    n_checks++; if (wv !== 32'hEE66_7788 || lat !== 3) begin n_fail++; $display("FAIL bst_out_v got %h lat=%0d exp ee667788/3", wv, lat); end
  endtask

  task automatic test_errors;
    int lat, wc; logic [31:0] rd, wv; logic er, rs, am;
    logic [1:0]  sz [6];
    logic [31:0] ad [6];
    logic        wr [6];
    sz[0] = 2'b10; ad[0] = 32'h0000_0102; wr[0] = 1'b0;
    sz[1] = 2'b01; ad[1] = 32'h0000_0301; wr[1] = 1'b1;
    sz[2] = 2'b11; ad[2] = 32'h0000_0100; wr[2] = 1'b0;
    sz[3] = 2'b10; ad[3] = 32'h0000_FFFD; wr[3] = 1'b0;
    sz[4] = 2'b00; ad[4] = 32'h0000_FFFD; wr[4] = 1'b0;
    sz[5] = 2'b10; ad[5] = 32'hFFFF_FFFC; wr[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_req(wr[i], sz[i], 1'b1, ad[i], 32'h1234_5678, lat, rd, er, wc, wv, rs, am);
      n_checks++; if (lat !== 1 || er !== 1'b1) begin n_fail++; $display("FAIL err_%0d_resp got lat=%0d err=%b exp 1/1", i, lat, er); end
      n_checks++; if (wc !== 0 || rs !== 1'b0 || am !== 1'b0) begin n_fail++; $display("FAIL err_%0d_quiet got wc=%0d read=%b a_moved=%b exp 0/0/0", i, wc, rs, am); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_%0d_rdata got %h exp 0", i, rd); end
    end
  endtask

  task automatic test_back_to_back;
    int acc, c1, c2, nresp, ntrans;
    logic [31:0] prev_a, r1, r2;
    acc = 0; c1 = -1; c2 = -1; nresp = 0; ntrans = 0; r1 = 32'h0; r2 = 32'h0;
    @(negedge mem_Clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0; req_valid = 1'b1;
    prev_a = data_memory_a;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (acc == 2) req_valid = 1'b0;
      if (prev_a === IDLE_A && data_memory_a === 32'h100) ntrans++;
      prev_a = data_memory_a;
      if (resp_valid) begin
        nresp++;
        if (nresp == 1) r1 = resp_rdata; else r2 = resp_rdata;
      end
      if (req_valid && req_ready) begin
        acc++;
        if (acc == 1) c1 = cyc; else c2 = cyc;
      end
      if (nresp == 2) break;
      @(negedge mem_Clk);
    end
    req_valid = 1'b0;
    n_checks++; if (acc !== 2 || nresp !== 2) begin n_fail++; $display("FAIL b2b_counts got acc=%0d resp=%0d exp 2/2", acc, nresp); end
    n_checks++; if (c2 - c1 !== 3) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 3", c2 - c1); end
    n_checks++; if (ntrans !== 2) begin n_fail++; $display("FAIL b2b_addr_transitions got %0d exp 2", ntrans); end
    n_checks++; if (r1 !== 32'hDEAD_BEEF || r2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_rdata got %h %h exp deadbeef", r1, r2); end
  endtask

  task automatic test_reset_mid_op;
    int wseen, rseen;
    wseen = 0; rseen = 0;
    poke(16'h0400, 32'hAABB_CCDD);
    @(negedge mem_Clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h400; req_wdata = 32'h0000_00EE; req_valid = 1'b1;
    @(posedge mem_Clk);
    #1;
    req_valid = 1'b0;
    @(negedge mem_Clk);
    n_checks++; if (data_memory_read !== 1'b1) begin n_fail++; $display("FAIL rmo_in_read got %b exp 1", data_memory_read); end
    mem_Reset_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmo_handshake got ready=%b resp=%b exp 0/0", req_ready, resp_valid); end
    n_checks++; if (data_memory_a !== IDLE_A || data_memory_read !== 1'b0 || data_memory_write !== 1'b0) begin n_fail++; $display("FAIL rmo_mem_side got a=%h r=%b w=%b exp %h/0/0", data_memory_a, data_memory_read, data_memory_write, IDLE_A); end
    n_checks++; if (resp_rdata !== 32'h0 || resp_error !== 1'b0 || data_memory_out_v !== 32'h0) begin n_fail++; $display("FAIL rmo_regs got rdata=%h err=%b out_v=%h exp 0", resp_rdata, resp_error, data_memory_out_v); end
    for (int i = 0; i < 3; i++) begin
      @(negedge mem_Clk);
      if (data_memory_write) wseen++;
      if (resp_valid) rseen++;
    end
    mem_Reset_n = 1'b1;
    @(negedge mem_Clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmo_ready_after got %b exp 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      if (data_memory_write) wseen++;
      if (resp_valid) rseen++;
      @(negedge mem_Clk);
    end
    n_checks++; if (wseen !== 0 || rseen !== 0) begin n_fail++; $display("FAIL rmo_no_activity got writes=%0d resps=%0d exp 0/0", wseen, rseen); end
    n_checks++; if ({mem[16'h0400], mem[16'h0401], mem[16'h0402], mem[16'h0403]} !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL rmo_mem_intact got %h exp aabbccdd", {mem[16'h0400], mem[16'h0401], mem[16'h0402], mem[16'h0403]}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mem_Reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) @(negedge mem_Clk);
    test_reset;
    test_word_rw;
    test_sub_loads;
    test_rmw_store;
    test_errors;
    test_back_to_back;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
